// File: rtl/pixel_pkg.sv
// Shared screen/engine constants and collector state encoding for the
// pixel pipeline (collector, distributor, raster counters).
package pixel_pkg;

  localparam int DEF_PIXEL_DATA_WIDTH = 10;
  localparam int DEF_SCREEN_WIDTH     = 640;
  localparam int DEF_SCREEN_HEIGHT    = 480;
  localparam int DEF_NUM_ENGINES      = 8;
  localparam int DEF_ITER_WIDTH       = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } collector_state_t;

  // Index width that stays legal for a single-entry batch.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position (px, py) that steps one pixel per advance pulse and
// wraps at the end of each line and frame.
module raster_counter
  import pixel_pkg::*;
#(
  parameter int WIDTH         = DEF_PIXEL_DATA_WIDTH,
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] px,
  output logic [WIDTH-1:0] py
);

  localparam logic [WIDTH-1:0] X_LAST = WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(SCREEN_HEIGHT - 1);

  logic [WIDTH-1:0] px_reg;
  logic [WIDTH-1:0] py_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      px_reg <= '0;
      py_reg <= '0;
    end else if (advance) begin
      if (px_reg == X_LAST) begin
        px_reg <= '0;
        py_reg <= (py_reg == Y_LAST) ? '0 : py_reg + 1'b1;
      end else begin
        px_reg <= px_reg + 1'b1;
      end
    end
  end

  assign px = px_reg;
  assign py = py_reg;

endmodule

// File: rtl/pixel_collector.sv
// Gathers one result per engine into a batch buffer, then streams the batch
// out in raster order with sof/eol markers and a fin_flag per drained batch.
module pixel_collector
  import pixel_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = DEF_PIXEL_DATA_WIDTH,
  parameter int SCREEN_WIDTH     = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT    = DEF_SCREEN_HEIGHT,
  parameter int NUM_ENGINES      = DEF_NUM_ENGINES,
  parameter int ITER_WIDTH       = DEF_ITER_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENGINES-1:0] eng_valid,
  input  logic [ITER_WIDTH-1:0]  eng_iter [NUM_ENGINES],
  output logic                   fin_flag,
  output logic [ITER_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol
);

  localparam int               K_W    = idx_width(NUM_ENGINES);
  localparam logic [K_W-1:0]   K_LAST = K_W'(NUM_ENGINES - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);

  collector_state_t            state_reg, state_next;
  logic [NUM_ENGINES-1:0]      got_reg, got_next;
  logic [NUM_ENGINES-1:0]      latch_en;
  logic [K_W-1:0]              k_reg, k_next;
  logic                        fin_reg, fin_next;
  logic [ITER_WIDTH-1:0]       buf_val [NUM_ENGINES];
  logic [PIXEL_DATA_WIDTH-1:0] px, py;
  logic                        handshake;

  // Only the first result of each engine per batch is captured.
  assign latch_en = (state_reg == COLLECT) ? (eng_valid & ~got_reg) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_buf
      logic [ITER_WIDTH-1:0] val_reg;
      always_ff @(posedge clk) begin
        if (latch_en[gi]) val_reg <= eng_iter[gi];
      end
      assign buf_val[gi] = val_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= COLLECT;
      got_reg   <= '0;
      k_reg     <= '0;
      fin_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      got_reg   <= got_next;
      k_reg     <= k_next;
      fin_reg   <= fin_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    got_next   = got_reg;
    k_next     = k_reg;
    fin_next   = 1'b0;
    unique case (state_reg)
      COLLECT: begin
        got_next = got_reg | eng_valid;
        if (&got_next) begin
          state_next = DRAIN;
          k_next     = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (k_reg == K_LAST) begin
            state_next = COLLECT;
            got_next   = '0;
            k_next     = '0;
            fin_next   = 1'b1;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  assign out_valid = (state_reg == DRAIN);
  assign out_data  = buf_val[k_reg];
  assign handshake = out_valid && out_ready;
  assign fin_flag  = fin_reg;
  assign out_sof   = out_valid && (px == '0) && (py == '0);
  assign out_eol   = out_valid && (px == X_LAST);

  raster_counter #(
    .WIDTH        (PIXEL_DATA_WIDTH),
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .advance(handshake),
    .px     (px),
    .py     (py)
  );

endmodule

// File: tb/tb_pixel_collector.sv
// Directed bench for pixel_collector: batch ordering, stalls, sticky capture,
// mid-drain reset and full-frame sof/eol placement.
`timescale 1ns/1ps
module tb_pixel_collector;
  import pixel_pkg::*;

  localparam int N  = 8;
  localparam int SW = 640;
  localparam int SH = 480;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] eng_valid = '0;
  logic [7:0]   eng_iter [N];
  logic         fin_flag;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_sof;
  logic         out_eol;

  int         check_count = 0;
  int         error_count = 0;
  int         exp_px = 0;
  int         exp_py = 0;
  logic [7:0] exp_vals [N];
  int         sof_seen = 0;
  int         eol_seen = 0;
  bit         verbose = 1'b1;

  always #5 clk = ~clk;

  pixel_collector dut (
    .clk      (clk),
    .reset    (reset),
    .eng_valid(eng_valid),
    .eng_iter (eng_iter),
    .fin_flag (fin_flag),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof  (out_sof),
    .out_eol  (out_eol)
  );

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d)", tag, actual, expected,
               exp_px, exp_py);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_model();
    if (exp_px == SW - 1) begin
      exp_px = 0;
      exp_py = (exp_py == SH - 1) ? 0 : exp_py + 1;
    end else begin
      exp_px = exp_px + 1;
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++) eng_iter[i] = exp_vals[i];
    eng_valid = '1;
    step();
    eng_valid = '0;
  endtask

  // Drains n_xfer pixels; with toggle set, out_ready alternates 1,0,1,0...
  task automatic drain_batch(input bit toggle, input int n_xfer);
    int j;
    int cyc;
    bit rdy;
    j = 0;
    cyc = 0;
    while (j < n_xfer && cyc < 4 * N) begin
      rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
      out_ready = rdy;
      check_value("valid", out_valid, 1);
      check_value("data", out_data, exp_vals[j]);
      check_value("sof", out_sof, (exp_px == 0 && exp_py == 0));
      check_value("eol", out_eol, (exp_px == SW - 1));
      check_value("fin_idle", fin_flag, 0);
      if (rdy) begin
        if (out_sof) sof_seen++;
        if (out_eol) eol_seen++;
        if (verbose)
          $display("xfer x=%0d y=%0d data=%0d sof=%0b eol=%0b", exp_px, exp_py,
                   out_data, out_sof, out_eol);
      end
      step();
      if (rdy) begin
        j++;
        advance_model();
      end
      cyc++;
    end
    out_ready = 1'b0;
    check_value("xfer_count", j, n_xfer);
    if (j == N) begin
      check_value("fin_pulse", fin_flag, 1);
      check_value("valid_after", out_valid, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) eng_iter[i] = 8'hEE;

    // Reset state
    repeat (3) step();
    check_value("rst_valid", out_valid, 0);
    check_value("rst_fin", fin_flag, 0);
    check_value("rst_sof", out_sof, 0);
    check_value("rst_eol", out_eol, 0);
    reset = 1'b0;

    // All engines at once, iter = i*3
    for (int i = 0; i < N; i++) exp_vals[i] = 8'(i * 3);
    load_all();
    drain_batch(1'b0, N);

    // Staggered completion, engine 7 first
    for (int i = 0; i < N; i++) exp_vals[i] = 8'(100 + i);
    for (int i = 0; i < N; i++) eng_iter[i] = 8'hEE;
    for (int s = N - 1; s >= 0; s--) begin
      eng_valid = '0;
      eng_valid[s] = 1'b1;
      eng_iter[s] = exp_vals[s];
      step();
      check_value("stagger_wait", out_valid, (s == 0));
    end
    eng_valid = '0;
    drain_batch(1'b0, N);

    // Stalling sink
    for (int i = 0; i < N; i++) exp_vals[i] = 8'(50 + i * 7);
    load_all();
    drain_batch(1'b1, N);
    step();
    check_value("no_dup_valid", out_valid, 0);
    check_value("fin_one_cycle", fin_flag, 0);

    // Re-asserted engine 2 keeps its first value
    for (int i = 0; i < N; i++) exp_vals[i] = 8'(10 + i);
    exp_vals[2] = 8'h55;
    for (int i = 0; i < N; i++) eng_iter[i] = 8'hEE;
    eng_valid = '0;
    eng_valid[2] = 1'b1;
    eng_iter[2] = 8'h55;
    step();
    check_value("sticky_wait0", out_valid, 0);
    eng_iter[2] = 8'hAA;
    step();
    check_value("sticky_wait1", out_valid, 0);
    for (int i = 0; i < N; i++) eng_iter[i] = exp_vals[i];
    eng_iter[2] = 8'h33;
    eng_valid = '1;
    step();
    eng_valid = '0;
    drain_batch(1'b0, N);

    // Reset after 3 of 8 transfers
    for (int i = 0; i < N; i++) exp_vals[i] = 8'(200 + i);
    load_all();
    drain_batch(1'b0, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_value("mid_rst_fin", fin_flag, 0);
    check_value("mid_rst_valid", out_valid, 0);
    step();
    check_value("mid_rst_fin2", fin_flag, 0);
    check_value("mid_rst_valid2", out_valid, 0);
    exp_px = 0;
    exp_py = 0;

    // Full frame from (0,0): eol at pixel 639 only, sof once per frame
    verbose = 1'b0;
    sof_seen = 0;
    eol_seen = 0;
    for (int b = 0; b < (SW * SH) / N; b++) begin
      for (int i = 0; i < N; i++) exp_vals[i] = 8'(b * N + i);
      load_all();
      drain_batch(1'b0, N);
      if (b == 0) check_value("post_rst_sof", sof_seen, 1);
      if (b == SW / N - 1) begin
        check_value("line0_eol", eol_seen, 1);
        check_value("line0_sof", sof_seen, 1);
      end
      if (b == SW / N) check_value("line1_no_sof", sof_seen, 1);
    end
    check_value("frame_eol", eol_seen, SH);
    check_value("frame_sof", sof_seen, 1);
    verbose = 1'b1;
    for (int i = 0; i < N; i++) exp_vals[i] = 8'(77 + i);
    load_all();
    drain_batch(1'b0, N);
    check_value("frame2_sof", sof_seen, 2);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
